// File: rtl/imm_decode_pipe.sv
// Two-stage decode-side immediate/target unit: S1 decodes format and immediate,
// S2 forms the PC-relative target and holds the outputs under valid/ready.
module imm_decode_pipe #(
  parameter int XLEN      = 32,
  parameter bit EN_ZICSR  = 1'b1,
  parameter bit EN_RV64OP = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_immediate,
  output logic [XLEN-1:0] o_target,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_ZIMM = 3'd6;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  logic            s1_valid_q, s1_valid_d;
  logic [2:0]      s1_fmt_q, s1_fmt_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;
  logic            s1_rel_q, s1_rel_d;

  logic            s2_valid_q, s2_valid_d;
  logic [2:0]      fmt_q, fmt_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            illegal_q, illegal_d;

  logic s1_move, retire, ready, accept;

  logic signed [11:0] raw_i, raw_s;
  logic signed [12:0] raw_b;
  logic signed [20:0] raw_j;
  logic signed [31:0] raw_u;
  logic [2:0]         dec_fmt;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_rel;

  assign retire  = s2_valid_q & i_ready;
  assign s1_move = s1_valid_q & (~s2_valid_q | i_ready);
  assign ready   = ~s1_valid_q | s1_move;
  assign accept  = i_valid & ready;

  assign raw_i = i_inst[31:20];
  assign raw_s = {i_inst[31:25], i_inst[11:7]};
  assign raw_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign raw_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign raw_u = {i_inst[31:12], 12'b0};

  // dec_rel marks formats whose target is pc+imm rather than pc+4
  always_comb begin
    dec_fmt = FMT_R;
    dec_imm = '0;
    dec_rel = 1'b0;
    unique case (i_inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'(raw_i);
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'(raw_s);
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'(raw_b);
        dec_rel = 1'b1;
      end
      OP_LUI: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'(raw_u);
      end
      OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'(raw_u);
        dec_rel = 1'b1;
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'(raw_j);
        dec_rel = 1'b1;
      end
      OP_OP: dec_fmt = FMT_R;
      OP_SYSTEM: begin
        if (EN_ZICSR && i_inst[14]) begin
          dec_fmt = FMT_ZIMM;
          dec_imm = XLEN'(i_inst[19:15]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'(raw_i);
        end
      end
      OP_IMM32: begin
        if (EN_RV64OP && XLEN == 64) begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'(raw_i);
        end else begin
          dec_fmt = FMT_ILL;
        end
      end
      default: dec_fmt = FMT_ILL;
    endcase
  end

  // Flush wins over any accept or transfer in the same cycle
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fmt_d   = s1_fmt_q;
    s1_imm_d   = s1_imm_q;
    s1_pc_d    = s1_pc_q;
    s1_rel_d   = s1_rel_q;
    if (i_flush)      s1_valid_d = 1'b0;
    else if (accept)  s1_valid_d = 1'b1;
    else if (s1_move) s1_valid_d = 1'b0;
    if (accept) begin
      s1_fmt_d = dec_fmt;
      s1_imm_d = dec_imm;
      s1_pc_d  = i_pc;
      s1_rel_d = dec_rel;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    fmt_d      = fmt_q;
    imm_d      = imm_q;
    target_d   = target_q;
    illegal_d  = illegal_q;
    if (i_flush)      s2_valid_d = 1'b0;
    else if (s1_move) s2_valid_d = 1'b1;
    else if (retire)  s2_valid_d = 1'b0;
    if (s1_move) begin
      fmt_d     = s1_fmt_q;
      imm_d     = s1_imm_q;
      illegal_d = (s1_fmt_q == FMT_ILL);
      target_d  = s1_pc_q + (s1_rel_q ? s1_imm_q : PC_STEP);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= '0;
      s1_imm_q   <= '0;
      s1_pc_q    <= '0;
      s1_rel_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      fmt_q      <= '0;
      imm_q      <= '0;
      target_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_imm_q   <= s1_imm_d;
      s1_pc_q    <= s1_pc_d;
      s1_rel_q   <= s1_rel_d;
      s2_valid_q <= s2_valid_d;
      fmt_q      <= fmt_d;
      imm_q      <= imm_d;
      target_q   <= target_d;
      illegal_q  <= illegal_d;
    end
  end

  assign o_ready     = ready;
  assign o_valid     = s2_valid_q;
  assign o_immediate = imm_q;
  assign o_target    = target_q;
  assign o_fmt       = fmt_q;
  assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: a 32-bit (ZICSR on) and a 64-bit (RV64OP on, ZICSR off)
// instance share one stimulus stream and are checked against a queue-based model.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, vin, rdy;
  logic [31:0] inst;
  logic [63:0] pc;

  logic        r32, v32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        r64, v64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    int          age;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .EN_ZICSR(1'b1), .EN_RV64OP(1'b0)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin), .o_ready(r32),
    .i_inst(inst), .i_pc(pc[31:0]), .o_valid(v32), .i_ready(rdy),
    .o_immediate(imm32), .o_target(tgt32), .o_fmt(fmt32), .o_illegal(ill32));

  imm_decode_pipe #(.XLEN(64), .EN_ZICSR(1'b0), .EN_RV64OP(1'b1)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin), .o_ready(r64),
    .i_inst(inst), .i_pc(pc), .o_valid(v64), .i_ready(rdy),
    .o_immediate(imm64), .o_target(tgt64), .o_fmt(fmt64), .o_illegal(ill64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    if (v[bits-1]) return v | (~64'd0 << bits);
    return v;
  endfunction

  function automatic void ref_dec(input logic [31:0] ins, input logic [63:0] p, input int xlen,
                                  input bit zicsr, input bit rv64op,
                                  output logic [2:0] fmt, output logic [63:0] imm,
                                  output logic [63:0] tgt, output logic ill);
    logic [63:0] w, mask;
    bit rel;
    w = {32'd0, ins};
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : ~64'd0;
    rel = 0; fmt = 3'd0; imm = 64'd0; ill = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin fmt = 3'd1; imm = sext(w >> 20, 12); end
      7'h23: begin fmt = 3'd2; imm = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12); end
      7'h63: begin
        fmt = 3'd3; rel = 1;
        imm = sext(((w >> 31) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5)
                   | (((w >> 8) & 15) << 1), 13);
      end
      7'h37: begin fmt = 3'd4; imm = sext(w & 64'hFFFF_F000, 32); end
      7'h17: begin fmt = 3'd4; imm = sext(w & 64'hFFFF_F000, 32); rel = 1; end
      7'h6F: begin
        fmt = 3'd5; rel = 1;
        imm = sext(((w >> 31) << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11)
                   | (((w >> 21) & 1023) << 1), 21);
      end
      7'h33: fmt = 3'd0;
      7'h73: begin
        if (zicsr && ins[14]) begin fmt = 3'd6; imm = (w >> 15) & 31; end
        else begin fmt = 3'd1; imm = sext(w >> 20, 12); end
      end
      7'h1B: begin
        if (rv64op && xlen == 64) begin fmt = 3'd1; imm = sext(w >> 20, 12); end
        else begin fmt = 3'd7; ill = 1'b1; end
      end
      default: begin fmt = 3'd7; ill = 1'b1; end
    endcase
    imm = imm & mask;
    tgt = (p + (rel ? imm : 64'd4)) & mask;
  endfunction

  task automatic compare_all();
    logic [2:0] f; logic [63:0] im, tg; logic il;
    bit ev;
    ev = (q.size() > 0) && (q[0].age >= 1);
    chk("valid32", v32, ev);
    chk("valid64", v64, ev);
    if (ev) begin
      ref_dec(q[0].inst, q[0].pc, 32, 1'b1, 1'b0, f, im, tg, il);
      chk("fmt32", fmt32, f); chk("imm32", imm32, im); chk("tgt32", tgt32, tg); chk("ill32", ill32, il);
      ref_dec(q[0].inst, q[0].pc, 64, 1'b0, 1'b1, f, im, tg, il);
      chk("fmt64", fmt64, f); chk("imm64", imm64, im); chk("tgt64", tgt64, tg); chk("ill64", ill64, il);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] p,
                      input bit r, input bit f);
    bit exp_rdy, ret;
    ent_t e;
    vin = v; inst = ins; pc = p; rdy = r; flush = f;
    #1;
    exp_rdy = (q.size() < 2) || r;
    chk("ready32", r32, exp_rdy);
    chk("ready64", r64, exp_rdy);
    if (f) begin
      q.delete();
    end else begin
      ret = (q.size() > 0) && (q[0].age >= 1) && r;
      if (ret) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (v && exp_rdy) begin
        e.inst = ins; e.pc = p; e.age = 0;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
  endtask

  // Issue one entry into an empty pipe and hold it in S2 for literal checks
  task automatic issue(input logic [31:0] ins, input logic [63:0] p);
    drain();
    step(1'b1, ins, p, 1'b0, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] x;
    int k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h1B, 7'h7F};
    x = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) x[6:0] = ops[k];
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 0; vin = 0; rdy = 0; inst = 0; pc = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid32", v32, 0); chk("rst_valid64", v64, 0);
    chk("rst_ready32", r32, 1); chk("rst_imm64", imm64, 0);
    chk("rst_tgt32", tgt32, 0); chk("rst_fmt64", fmt64, 0); chk("rst_ill32", ill32, 0);
    rst_n = 1'b1;

    // beq x2,x0 with B-immediate -2
    issue(32'hFE010FE3, 64'h100);
    chk("beq2_fmt", fmt32, 3); chk("beq2_imm", imm32, 32'hFFFF_FFFE); chk("beq2_tgt", tgt32, 32'hFE);
    // beq x0,x0,-32
    issue(32'hFE0000E3, 64'h100);
    chk("beq32_fmt", fmt32, 3); chk("beq32_imm", imm32, 32'hFFFF_FFE0); chk("beq32_tgt", tgt32, 32'hE0);
    chk("beq64_imm", imm64, 64'hFFFF_FFFF_FFFF_FFE0); chk("beq64_tgt", tgt64, 64'hE0);
    issue(32'h800002B7, 64'h0);
    chk("lui_fmt", fmt64, 4); chk("lui_imm", imm64, 64'hFFFF_FFFF_8000_0000); chk("lui_tgt", tgt64, 64'h4);
    issue(32'h3401D073, 64'h200);
    chk("csr_fmt32", fmt32, 6); chk("csr_imm32", imm32, 3);
    chk("csr_fmt64", fmt64, 1); chk("csr_imm64", imm64, 64'h340);
    issue(32'h0000007F, 64'h300);
    chk("ill_fmt", fmt32, 7); chk("ill_flag", ill32, 1); chk("ill_imm", imm32, 0);
    issue(32'h0010011B, 64'h0);
    chk("addiw_fmt64", fmt64, 1); chk("addiw_imm64", imm64, 1); chk("addiw_ill32", ill32, 1);
    issue(32'h0000006F, 64'hFFFF_FFFC);
    chk("jal0_tgt32", tgt32, 32'hFFFF_FFFC);
    // jal +8 from the top of the 32-bit space wraps to 4
    issue(32'h0080006F, 64'hFFFF_FFFC);
    chk("jal8_tgt32", tgt32, 32'h4); chk("jal8_tgt64", tgt64, 64'h1_0000_0004);

    // back-to-back accepts then a 5-cycle stall
    drain();
    step(1'b1, 32'h00500013, 64'h40, 1'b0, 1'b0);
    step(1'b1, 32'h00A00093, 64'h44, 1'b0, 1'b0);
    chk("full_ready", r32, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_inst(), 64'h48, 1'b0, 1'b0);
      chk("stall_imm", imm32, 5);
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("order_second", imm32, 10);
    drain();

    // flush with two in flight and a simultaneous accept
    step(1'b1, 32'h00100013, 64'h10, 1'b0, 1'b0);
    step(1'b1, 32'h00200013, 64'h14, 1'b0, 1'b0);
    step(1'b1, 32'h00300013, 64'h18, 1'b1, 1'b1);
    chk("flush_valid", v32, 0);
    chk("flush_ready", r64, 1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // reset during a stall
    step(1'b1, 32'h0080006F, 64'hFFFF_FFFC, 1'b0, 1'b0);
    step(1'b1, 32'h00A00093, 64'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid32", v32, 0); chk("mrst_valid64", v64, 0);
    chk("mrst_imm32", imm32, 0); chk("mrst_tgt64", tgt64, 0); chk("mrst_ready", r32, 1);
    q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, rand_inst(), {$urandom, $urandom}, ($urandom % 3) != 0,
           ($urandom % 50) == 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
